// File: rtl/conv_frame_writer.sv
// Captures one frame of convolution output and streams it to memory through a
// small holding FIFO; pixels arriving while the FIFO is full are counted but dropped.
//
// state   | meaning
// IDLE    | waiting for start, pixels ignored, frame results held
// CAPTURE | accepting valid pixels, writing FIFO head to memory
// DRAIN   | frame fully accepted, emptying FIFO to memory
// DONE    | one-cycle frame_done pulse, then IDLE
module conv_frame_writer #(
  parameter int          WORD_SIZE  = 8,
  parameter int          OUT_COLS   = 538,
  parameter int          OUT_ROWS   = 538,
  parameter int          FIFO_DEPTH = 8,
  parameter int          ADDR_WIDTH = 20,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [WORD_SIZE-1:0]                    pixel_in,
  input  logic [1:0]                              pixel_valid,
  output logic                                    mem_we,
  output logic [ADDR_WIDTH-1:0]                   mem_addr,
  output logic [WORD_SIZE-1:0]                    mem_data,
  input  logic                                    mem_ready,
  output logic                                    busy,
  output logic                                    frame_done,
  output logic                                    overflow,
  output logic [$clog2(OUT_COLS*OUT_ROWS+1)-1:0]  pixel_count
);

  localparam int TOTAL = OUT_COLS * OUT_ROWS;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int PW    = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0]         TOTAL_C = CW'(TOTAL);
  localparam logic [PW:0]           DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BASE_C  = ADDR_WIDTH'(BASE_ADDR);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [WORD_SIZE-1:0]  fifo_q [FIFO_DEPTH];
  logic [WORD_SIZE-1:0]  fifo_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         pcount_q, pcount_d;
  logic                  ovf_q, ovf_d;

  logic                  active;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;
  logic                  accept;
  logic                  push;
  logic [CW-1:0]         pcount_inc;

  always_comb begin
    active     = (state_q == CAPTURE) || (state_q == DRAIN);
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == DEPTH_C);
    pop        = active && !fifo_empty && mem_ready;
    accept     = (state_q == CAPTURE) && (|pixel_valid);
    // A full FIFO still takes the pixel when the head leaves in the same cycle.
    push       = accept && (!fifo_full || pop);
    pcount_inc = pcount_q + CW'(1);
  end

  always_comb begin
    state_d  = state_q;
    pcount_d = pcount_q;
    addr_d   = addr_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    fifo_d   = fifo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CAPTURE;
          pcount_d = '0;
          addr_d   = BASE_C;
          ovf_d    = 1'b0;
        end
      end
      CAPTURE: begin
        if (accept) begin
          pcount_d = pcount_inc;
          if (!push) begin
            ovf_d = 1'b1;
          end
          if (pcount_inc == TOTAL_C) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      addr_d   = addr_q + ADDR_WIDTH'(1);
    end

    if (push) begin
      fifo_d[wr_ptr_q] = pixel_in;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= BASE_C;
      pcount_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      pcount_q <= pcount_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  always_comb begin
    mem_we      = active && !fifo_empty;
    mem_addr    = addr_q;
    mem_data    = mem_we ? fifo_q[rd_ptr_q] : '0;
    busy        = active;
    frame_done  = (state_q == DONE);
    overflow    = ovf_q;
    pixel_count = pcount_q;
  end

endmodule

// File: tb/tb_conv_frame_writer.sv
// Randomized and directed bench for conv_frame_writer, checked every cycle
// against a queue-based reference model of the frame writer.
module tb_conv_frame_writer;

  localparam int WS    = 8;
  localparam int OC    = 4;
  localparam int ORW   = 3;
  localparam int FD    = 4;
  localparam int AW    = 20;
  localparam int BASE  = 'h100;
  localparam int TOTAL = OC * ORW;
  localparam int CW    = $clog2(TOTAL + 1);

  localparam int P_IDLE  = 0;
  localparam int P_CAP   = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [WS-1:0] pixel_in = '0;
  logic [1:0]    pixel_valid = '0;
  logic          mem_ready = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [WS-1:0] mem_data;
  logic          busy;
  logic          frame_done;
  logic          overflow;
  logic [CW-1:0] pixel_count;

  conv_frame_writer #(
    .WORD_SIZE(WS), .OUT_COLS(OC), .OUT_ROWS(ORW), .FIFO_DEPTH(FD),
    .ADDR_WIDTH(AW), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pixel_in(pixel_in),
    .pixel_valid(pixel_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ready(mem_ready), .busy(busy),
    .frame_done(frame_done), .overflow(overflow), .pixel_count(pixel_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: frame phase, queue of pixels awaiting write
  int            m_phase = P_IDLE;
  logic [WS-1:0] m_q[$];
  int            m_addr  = BASE;
  int            m_count = 0;
  bit            m_ovf   = 1'b0;
  int            m_drops = 0;

  int            wr_seen   = 0;
  int            done_seen = 0;
  logic [31:0]   last_addr = '0;
  logic [31:0]   last_data = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic st, input logic [1:0] pv, input logic [WS-1:0] px,
                       input logic rdy, input logic rs);
    bit exp_we;
    bit pop;
    bit acc;
    @(negedge clk);
    start = st; pixel_valid = pv; pixel_in = px; mem_ready = rdy; rst = rs;
    #1;
    exp_we = (m_phase == P_CAP || m_phase == P_DRAIN) && (m_q.size() > 0);
    check_val("mem_we", mem_we, exp_we);
    check_val("mem_addr", mem_addr, m_addr);
    if (exp_we) check_val("mem_data", mem_data, m_q[0]);
    check_val("busy", busy, (m_phase == P_CAP || m_phase == P_DRAIN));
    check_val("frame_done", frame_done, m_phase == P_DONE);
    check_val("overflow", overflow, m_ovf);
    check_val("pixel_count", pixel_count, m_count);
    if (mem_we && rdy && !rs) begin
      wr_seen++;
      last_addr = mem_addr;
      last_data = mem_data;
    end
    if (frame_done) done_seen++;
    @(posedge clk);
    if (rs) begin
      m_phase = P_IDLE; m_q.delete(); m_addr = BASE; m_count = 0; m_ovf = 0; m_drops = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (st) begin
          m_phase = P_CAP; m_count = 0; m_addr = BASE; m_ovf = 0; m_drops = 0;
        end
        P_CAP, P_DRAIN: begin
          pop = (m_q.size() > 0) && rdy;
          acc = (m_phase == P_CAP) && (pv != 0);
          if (m_phase == P_DRAIN && m_q.size() == 0) m_phase = P_DONE;
          if (pop) begin
            m_q.delete(0);
            m_addr++;
          end
          if (acc) begin
            m_count++;
            if (m_q.size() < FD) m_q.push_back(px);
            else begin
              m_ovf = 1'b1;
              m_drops++;
            end
            if (m_count == TOTAL) m_phase = P_DRAIN;
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  // mode 0: back-to-back, 1: gapped + mixed qualifiers + stray start,
  // 2: memory stall mid-burst, 3: fill then pop+push, 4: random
  task automatic frame(input int mode);
    int sent;
    int cyc;
    int n;
    int d0;
    int w0;
    logic [1:0]    pv;
    logic          r;
    logic          st;
    logic [WS-1:0] px;
    sent = 0; cyc = 0; n = 0;
    d0 = done_seen; w0 = wr_seen;
    cycle(1'b1, 2'b00, '0, 1'b1, 1'b0);
    while (sent < TOTAL && cyc < 200) begin
      st = 1'b0;
      px = WS'(sent + 1);
      case (mode)
        0: begin pv = 2'b01; r = 1'b1; end
        1: begin
          pv = (cyc % 3 == 1) ? 2'b00 : ((cyc % 2 == 1) ? 2'b11 : 2'b01);
          r  = 1'b1;
          st = (cyc == 3);
        end
        2: begin pv = 2'b10; r = !(cyc >= 2 && cyc < 8); end
        3: begin pv = 2'b01; r = (cyc >= 4); end
        default: begin
          pv = 2'($urandom_range(0, 3));
          r  = ($urandom_range(0, 3) != 0);
          st = ($urandom_range(0, 7) == 0);
          px = WS'($urandom_range(0, 255));
        end
      endcase
      cycle(st, pv, px, r, 1'b0);
      if (pv != 0) sent++;
      cyc++;
    end
    while (m_phase != P_IDLE && n < 64) begin
      r = (mode == 4) ? ($urandom_range(0, 1) == 1) : 1'b1;
      cycle(1'b0, 2'($urandom_range(0, 3)), 8'hEE, r, 1'b0);
      n++;
    end
    check_val("frame_end_busy", busy, 0);
    check_val("done_pulses", done_seen - d0, 1);
    check_val("frame_pc", pixel_count, TOTAL);
    check_val("frame_writes", wr_seen - w0, TOTAL - m_drops);
    check_val("frame_ovf", overflow, m_drops > 0);
    if (mode == 0) begin
      check_val("last_addr", last_addr, BASE + TOTAL - 1);
      check_val("last_data", last_data, TOTAL);
    end
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    cycle(1'b0, 2'b00, '0, 1'b0, 1'b1);
    check_val("rst_data", mem_data, 0);
    check_val("rst_addr", mem_addr, BASE);

    frame(0);
    frame(1);
    repeat (5) cycle(1'b0, 2'b11, 8'h55, 1'b1, 1'b0);
    check_val("idle_pc_hold", pixel_count, TOTAL);
    frame(2);
    check_val("stall_ovf", overflow, 1);
    frame(3);
    check_val("full_pop_ovf", overflow, 0);

    cycle(1'b1, 2'b00, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 2'b01, WS'(i + 1), 1'b1, 1'b0);
    d0 = done_seen;
    cycle(1'b1, 2'b01, 8'h09, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, 2'b00, '0, 1'b1, 1'b0);
    check_val("rst_mid_done", done_seen - d0, 0);
    check_val("rst_mid_busy", busy, 0);
    check_val("rst_mid_pc", pixel_count, 0);
    check_val("rst_mid_data", mem_data, 0);
    frame(0);

    cycle(1'b1, 2'b00, '0, 1'b1, 1'b0);
    repeat (40) cycle(1'b0, 2'b00, 8'h77, 1'b1, 1'b0);
    check_val("stuck_busy", busy, 1);
    cycle(1'b0, 2'b00, '0, 1'b1, 1'b1);

    repeat (20) frame(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_frame_writer.md
CONV_FRAME_WRITER -- requirements
Module: conv_frame_writer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8: pixel width.
REQ-002 SHALL have parameter OUT_COLS, default 538: output pixels per row.
REQ-003 SHALL have parameter OUT_ROWS, default 538: output rows per frame.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, power of two, >=2: holding FIFO entries.
REQ-005 SHALL have parameter ADDR_WIDTH, default 20: memory address width.
REQ-006 SHALL have parameter BASE_ADDR, default 0: address of first frame pixel.
REQ-007 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-008 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-009 SHALL have port start  input  1  arm capture of one frame.
REQ-010 SHALL have port pixel_in  input  WORD_SIZE  filtered pixel from convolution stage.
REQ-011 SHALL have port pixel_valid  input  2  pixel qualifier; pixel valid when nonzero.
REQ-012 SHALL have port mem_we  output  1  write request, head of FIFO presented.
REQ-013 SHALL have port mem_addr  output  ADDR_WIDTH  write address.
REQ-014 SHALL have port mem_data  output  WORD_SIZE  write data.
REQ-015 SHALL have port mem_ready  input  1  memory accepts write this cycle.
REQ-016 SHALL have port busy  output  1  high in CAPTURE or DRAIN.
REQ-017 SHALL have port frame_done  output  1  one-cycle pulse at end of frame.
REQ-018 SHALL have port overflow  output  1  sticky: pixel dropped on full FIFO.
REQ-019 SHALL have port pixel_count  output  $clog2(OUT_COLS*OUT_ROWS+1)  pixels accepted this frame.

Function
REQ-020 SHALL implement FSM states IDLE, CAPTURE, DRAIN, DONE.
REQ-021 IDLE: start=1 -> CAPTURE next cycle; pixel_count, write address (BASE_ADDR), overflow cleared; pixels ignored.
REQ-022 start outside IDLE SHALL be ignored.
REQ-023 CAPTURE: each cycle with pixel_valid!=0 SHALL accept one pixel and increment pixel_count.
REQ-024 Accepted pixel SHALL be pushed to FIFO if not full, or if full with a pop in the same cycle.
REQ-025 Accepted pixel with FIFO full and no same-cycle pop SHALL be dropped, still counted, and set overflow.
REQ-026 When pixel_count reaches OUT_COLS*OUT_ROWS (including the accepting cycle) SHALL go to DRAIN; later valid pixels ignored.
REQ-027 mem_we SHALL equal FIFO non-empty in CAPTURE/DRAIN, 0 otherwise; mem_data = FIFO head; mem_addr = write address register.
REQ-028 A write completes on an edge with mem_we=1 and mem_ready=1: FIFO pops, write address increments by 1.
REQ-029 mem_addr/mem_data SHALL hold stable while mem_we=1 and mem_ready=0.
REQ-030 Latency: pixel accepted into empty FIFO at edge N SHALL appear with mem_we=1 in cycle after edge N.
REQ-031 Write addresses SHALL be consecutive per written pixel; dropped pixels consume no address.
REQ-032 DRAIN: when FIFO empty SHALL go to DONE; DONE asserts frame_done for exactly one cycle, then IDLE.
REQ-033 Frame of all-invalid input SHALL stay in CAPTURE indefinitely (no timeout).
REQ-034 pixel_count and overflow SHALL hold their values in IDLE after frame until next accepted start.

Reset
REQ-035 rst=1 SHALL force IDLE, empty FIFO, mem_we=0, mem_addr=BASE_ADDR, mem_data=0, busy=0, frame_done=0, overflow=0, pixel_count=0.
REQ-036 rst mid-frame SHALL abandon the frame without frame_done; rst SHALL take priority over start.

Verification (OUT_COLS=4, OUT_ROWS=3, FIFO_DEPTH=4, BASE_ADDR=0x100)
REQ-037 Start, 12 consecutive valid pixels 1..12, mem_ready=1 -> writes addr 0x100..0x10B data 1..12, frame_done one pulse, overflow=0, pixel_count=12.
REQ-038 Valid gapped by pixel_valid=0 cycles, pixel_valid=2'b01 and 2'b11 mixed -> all 12 written in order, no extras.
REQ-039 mem_ready=0 for 6 cycles during 12-pixel burst -> first 4 buffered, remaining dropped pixels set overflow, frame_done still pulses, addresses contiguous.
REQ-040 Full FIFO with mem_ready=1 and valid pixel same cycle -> push accepted, no overflow.
REQ-041 rst after 5 pixels -> outputs at reset values next cycle, no frame_done; new start writes from 0x100.
REQ-042 Pixels while IDLE and start during CAPTURE -> ignored, pixel_count unaffected.
